// File: rtl/spi_byte_engine.sv
// spi_byte_engine: SPI mode-0 byte shifter with CPU-written slave selects.
// Define OPEN_ED_SPI_AUTOREAD_EN to let rd_strobe launch an 8'hFF transfer.
module spi_byte_engine #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_strobe,
    input  logic [7:0] wr_data,
    input  logic       cs_wr,
    input  logic [1:0] cs_data,
    input  logic       rd_strobe,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_ss_n1,
    output logic       spi_ss_n2
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;
    state_t     state_q;
    logic [7:0] div_q, tx_q, rx_q, rd_q;
    logic [2:0] bit_q;
    logic       sck_q, busy_q, done_q, ss1_q, ss2_q, pend_q;
    logic [1:0] pend_cs_q;
    logic       start_d, tick_d;
    logic [7:0] load_d;
    logic [1:0] cs_end_d;
`ifdef OPEN_ED_SPI_AUTOREAD_EN
    assign start_d = wr_strobe | rd_strobe;
`else
    logic unused_rd;
    assign unused_rd = rd_strobe;
    assign start_d = wr_strobe;
`endif
    assign load_d   = wr_strobe ? wr_data : 8'hFF;
    assign tick_d   = div_q == 8'(CLK_DIV - 1);
    assign cs_end_d = cs_wr ? cs_data : pend_cs_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            div_q     <= 8'd0;
            bit_q     <= 3'd0;
            tx_q      <= 8'hFF;
            rx_q      <= 8'hFF;
            rd_q      <= 8'hFF;
            sck_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ss1_q     <= 1'b1;
            ss2_q     <= 1'b1;
            pend_q    <= 1'b0;
            pend_cs_q <= 2'b00;
        end else begin
            done_q <= 1'b0;
            // selects written mid-byte wait for the end of the transfer
            if (cs_wr && state_q != IDLE) {pend_q, pend_cs_q} <= {1'b1, cs_data};
            case (state_q)
                IDLE: begin
                    if (cs_wr) {ss2_q, ss1_q} <= ~cs_data;
                    if (start_d) begin
                        tx_q    <= load_d;
                        bit_q   <= 3'd7;
                        div_q   <= 8'd0;
                        busy_q  <= 1'b1;
                        state_q <= LOW;
                    end
                end
                LOW: begin
                    if (tick_d) begin
                        sck_q   <= 1'b1;
                        rx_q    <= {rx_q[6:0], spi_miso};
                        div_q   <= 8'd0;
                        state_q <= HIGH;
                    end else div_q <= div_q + 8'd1;
                end
                HIGH: begin
                    if (tick_d) begin
                        sck_q <= 1'b0;
                        div_q <= 8'd0;
                        if (bit_q == 3'd0) begin
                            rd_q    <= rx_q;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pend_q  <= 1'b0;
                            state_q <= IDLE;
                            if (cs_wr || pend_q) {ss2_q, ss1_q} <= ~cs_end_d;
                        end else begin
                            tx_q    <= {tx_q[6:0], 1'b1};
                            bit_q   <= bit_q - 3'd1;
                            state_q <= LOW;
                        end
                    end else div_q <= div_q + 8'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign rd_data   = rd_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign spi_sck   = sck_q;
    assign spi_mosi  = tx_q[7];
    assign spi_ss_n1 = ss1_q;
    assign spi_ss_n2 = ss2_q;
endmodule

// File: tb/tb_spi_byte_engine.sv
// tb_spi_byte_engine: directed checks of spi_byte_engine at CLK_DIV=2 and CLK_DIV=1.
module tb_spi_byte_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr_1 = 1'b0, wr_2 = 1'b0, cs_wr = 1'b0, rd = 1'b0;
    logic [7:0] wd_1 = 8'h00, wd_2 = 8'h00;
    logic [1:0] cs_data = 2'b00;
    logic [7:0] rdd_1, rdd_2;
    logic busy_1, busy_2, done_1, done_2, sck_1, sck_2, mosi_1, mosi_2, miso_1, miso_2;
    logic ss1_1, ss2_1, ss1_2, ss2_2;
    logic [7:0] sb1 = 8'h00, sb2 = 8'h00, msh1 = 8'h00, msh2 = 8'h00;
    logic [2:0] fc1 = 3'd0, fc2 = 3'd0;
    int rise2 = 0, bc1 = 0, bc2 = 0, dc1 = 0, dc2 = 0;
    int chk = 0, pass = 0;

    always #5 clk = ~clk;

    spi_byte_engine #(.CLK_DIV(2)) u2 (
        .clk(clk), .rst(rst), .wr_strobe(wr_2), .wr_data(wd_2), .cs_wr(cs_wr), .cs_data(cs_data),
        .rd_strobe(rd), .rd_data(rdd_2), .busy(busy_2), .done(done_2), .spi_sck(sck_2),
        .spi_mosi(mosi_2), .spi_miso(miso_2), .spi_ss_n1(ss1_2), .spi_ss_n2(ss2_2));
    spi_byte_engine #(.CLK_DIV(1)) u1 (
        .clk(clk), .rst(rst), .wr_strobe(wr_1), .wr_data(wd_1), .cs_wr(cs_wr), .cs_data(cs_data),
        .rd_strobe(rd), .rd_data(rdd_1), .busy(busy_1), .done(done_1), .spi_sck(sck_1),
        .spi_mosi(mosi_1), .spi_miso(miso_1), .spi_ss_n1(ss1_1), .spi_ss_n2(ss2_1));

    // slave model: MSB first, shifts on the falling SCK edge
    assign miso_2 = sb2[~fc2];
    assign miso_1 = sb1[~fc1];
    always @(negedge sck_2 or posedge rst) if (rst) fc2 <= 3'd0; else fc2 <= fc2 + 3'd1;
    always @(negedge sck_1 or posedge rst) if (rst) fc1 <= 3'd0; else fc1 <= fc1 + 3'd1;
    always @(posedge sck_2) begin
        rise2 <= rise2 + 1;
        msh2 <= {msh2[6:0], mosi_2};
    end
    always @(posedge sck_1) msh1 <= {msh1[6:0], mosi_1};
    always @(negedge clk) begin
        if (busy_1) bc1 <= bc1 + 1;
        if (busy_2) bc2 <= bc2 + 1;
        if (done_1) dc1 <= dc1 + 1;
        if (done_2) dc2 <= dc2 + 1;
    end

    task automatic start2(input logic [7:0] b);
        @(posedge clk); #1 wr_2 = 1'b1; wd_2 = b;
        @(posedge clk); #1 wr_2 = 1'b0;
    endtask

    task automatic wait_done2;
        for (int k = 0; k < 200; k++) begin
            if (done_2) break;
            @(posedge clk); #1;
        end
        chk++; if (done_2 !== 1'b1) $display("FAIL done2_timeout got %b exp 1", done_2); else pass++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk++; if (sck_2 !== 1'b0) $display("FAIL rst_sck got %b exp 0", sck_2); else pass++;
        chk++; if (mosi_2 !== 1'b1) $display("FAIL rst_mosi got %b exp 1", mosi_2); else pass++;
        chk++; if ({ss2_2, ss1_2} !== 2'b11) $display("FAIL rst_ss got %b exp 11", {ss2_2, ss1_2}); else pass++;
        chk++; if (busy_2 !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy_2); else pass++;
        chk++; if (done_2 !== 1'b0) $display("FAIL rst_done got %b exp 0", done_2); else pass++;
        chk++; if (rdd_2 !== 8'hFF) $display("FAIL rst_rd got %h exp ff", rdd_2); else pass++;
        chk++; if (rdd_1 !== 8'hFF) $display("FAIL rst_rd1 got %h exp ff", rdd_1); else pass++;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_basic;
        int r0, b0, d0;
        sb2 = 8'h3C; r0 = rise2; b0 = bc2; d0 = dc2;
        start2(8'hA5);
        chk++; if (busy_2 !== 1'b1) $display("FAIL basic_busy got %b exp 1", busy_2); else pass++;
        chk++; if (mosi_2 !== 1'b1) $display("FAIL basic_mosi0 got %b exp 1", mosi_2); else pass++;
        @(posedge clk); #1;
        chk++; if (sck_2 !== 1'b0) $display("FAIL basic_sck_early got %b exp 0", sck_2); else pass++;
        @(posedge clk); #1;
        chk++; if (sck_2 !== 1'b1) $display("FAIL basic_sck_rise got %b exp 1", sck_2); else pass++;
        wait_done2;
        chk++; if (rdd_2 !== 8'h3C) $display("FAIL basic_rd got %h exp 3c", rdd_2); else pass++;
        chk++; if (busy_2 !== 1'b0) $display("FAIL basic_busy_end got %b exp 0", busy_2); else pass++;
        chk++; if (rise2 - r0 !== 8) $display("FAIL basic_rises got %0d exp 8", rise2 - r0); else pass++;
        chk++; if (msh2 !== 8'hA5) $display("FAIL basic_mosi got %h exp a5", msh2); else pass++;
        @(posedge clk); #1;
        chk++; if (done_2 !== 1'b0) $display("FAIL basic_done_width got %b exp 0", done_2); else pass++;
        chk++; if (bc2 - b0 !== 32) $display("FAIL basic_busy_cycles got %0d exp 32", bc2 - b0); else pass++;
        chk++; if (dc2 - d0 !== 1) $display("FAIL basic_dones got %0d exp 1", dc2 - d0); else pass++;
    endtask

    task automatic test_back_to_back;
        int b0, d0, n;
        sb1 = 8'hC3; b0 = bc1; d0 = dc1;
        @(posedge clk); #1 wr_1 = 1'b1; wd_1 = 8'h00;
        @(posedge clk); #1 wr_1 = 1'b0;
        for (n = 1; n < 100; n++) begin
            @(posedge clk); #1;
            if (done_1) break;
        end
        chk++; if (n !== 16) $display("FAIL b2b_len1 got %0d exp 16", n); else pass++;
        chk++; if (rdd_1 !== 8'hC3) $display("FAIL b2b_rd1 got %h exp c3", rdd_1); else pass++;
        chk++; if (msh1 !== 8'h00) $display("FAIL b2b_mosi1 got %h exp 00", msh1); else pass++;
        wr_1 = 1'b1; wd_1 = 8'hFF;
        @(posedge clk); #1 wr_1 = 1'b0;
        chk++; if (busy_1 !== 1'b1) $display("FAIL b2b_restart got %b exp 1", busy_1); else pass++;
        for (n = 1; n < 100; n++) begin
            @(posedge clk); #1;
            if (done_1) break;
        end
        chk++; if (n !== 16) $display("FAIL b2b_len2 got %0d exp 16", n); else pass++;
        chk++; if (rdd_1 !== 8'hC3) $display("FAIL b2b_rd2 got %h exp c3", rdd_1); else pass++;
        chk++; if (msh1 !== 8'hFF) $display("FAIL b2b_mosi2 got %h exp ff", msh1); else pass++;
        @(posedge clk); #1;
        chk++; if (mosi_1 !== 1'b1) $display("FAIL b2b_mosi_idle got %b exp 1", mosi_1); else pass++;
        chk++; if (bc1 - b0 !== 32) $display("FAIL b2b_busy_cycles got %0d exp 32", bc1 - b0); else pass++;
        chk++; if (dc1 - d0 !== 2) $display("FAIL b2b_dones got %0d exp 2", dc1 - d0); else pass++;
    endtask

    task automatic test_cs_pending;
        logic bad;
        bad = 1'b0; sb2 = 8'h3C;
        start2(8'h55);
        repeat (5) @(posedge clk);
        #1 cs_wr = 1'b1; cs_data = 2'b01;
        @(posedge clk); #1 cs_wr = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (busy_2 && {ss2_2, ss1_2} !== 2'b11) bad = 1'b1;
            if (done_2) break;
            @(posedge clk); #1;
        end
        chk++; if (bad !== 1'b0) $display("FAIL cs_midbyte got %b exp 0", bad); else pass++;
        chk++; if (done_2 !== 1'b1) $display("FAIL cs_timeout got %b exp 1", done_2); else pass++;
        chk++; if (ss1_2 !== 1'b0) $display("FAIL cs_ss1_end got %b exp 0", ss1_2); else pass++;
        chk++; if (ss2_2 !== 1'b1) $display("FAIL cs_ss2_end got %b exp 1", ss2_2); else pass++;
        @(posedge clk); #1 cs_wr = 1'b1; cs_data = 2'b00;
        @(posedge clk); #1 cs_wr = 1'b0;
        chk++; if (ss1_2 !== 1'b1) $display("FAIL cs_idle_deselect got %b exp 1", ss1_2); else pass++;
    endtask

    task automatic test_wr_ignored;
        int b0, d0;
        sb2 = 8'h3C; b0 = bc2; d0 = dc2;
        start2(8'h81);
        repeat (14) @(posedge clk);
        #1 wr_2 = 1'b1; wd_2 = 8'h12;
        @(posedge clk); #1 wr_2 = 1'b0;
        wait_done2;
        chk++; if (msh2 !== 8'h81) $display("FAIL ign_mosi got %h exp 81", msh2); else pass++;
        repeat (40) @(posedge clk);
        #1;
        chk++; if (dc2 - d0 !== 1) $display("FAIL ign_dones got %0d exp 1", dc2 - d0); else pass++;
        chk++; if (bc2 - b0 !== 32) $display("FAIL ign_busy_cycles got %0d exp 32", bc2 - b0); else pass++;
    endtask

    task automatic test_reset_mid;
        int d0;
        @(posedge clk); #1 cs_wr = 1'b1; cs_data = 2'b11;
        @(posedge clk); #1 cs_wr = 1'b0;
        chk++; if ({ss2_2, ss1_2} !== 2'b00) $display("FAIL rm_select got %b exp 00", {ss2_2, ss1_2}); else pass++;
        d0 = dc2; sb2 = 8'h5A;
        start2(8'hAA);
        repeat (17) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk++; if (sck_2 !== 1'b0) $display("FAIL rm_sck got %b exp 0", sck_2); else pass++;
        chk++; if (mosi_2 !== 1'b1) $display("FAIL rm_mosi got %b exp 1", mosi_2); else pass++;
        chk++; if ({ss2_2, ss1_2} !== 2'b11) $display("FAIL rm_ss got %b exp 11", {ss2_2, ss1_2}); else pass++;
        chk++; if (busy_2 !== 1'b0) $display("FAIL rm_busy got %b exp 0", busy_2); else pass++;
        chk++; if (rdd_2 !== 8'hFF) $display("FAIL rm_rd got %h exp ff", rdd_2); else pass++;
        @(posedge clk); #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk++; if (dc2 !== d0) $display("FAIL rm_no_done got %0d exp %0d", dc2, d0); else pass++;
        sb2 = 8'h96;
        start2(8'hC3);
        wait_done2;
        chk++; if (rdd_2 !== 8'h96) $display("FAIL rm_after_rd got %h exp 96", rdd_2); else pass++;
        chk++; if (msh2 !== 8'hC3) $display("FAIL rm_after_mosi got %h exp c3", msh2); else pass++;
        @(posedge clk); #1;
    endtask

`ifdef OPEN_ED_SPI_AUTOREAD_EN
    task automatic test_autoread;
        logic [7:0] sv [3];
        logic [7:0] prev;
        sv = '{8'h11, 8'h22, 8'h33};
        prev = 8'h96;
        for (int i = 0; i < 3; i++) begin
            sb2 = sv[i];
            rd = 1'b1;
            chk++; if (rdd_2 !== prev) $display("FAIL ar_prev%0d got %h exp %h", i, rdd_2, prev); else pass++;
            @(posedge clk); #1 rd = 1'b0;
            wait_done2;
            chk++; if (msh2 !== 8'hFF) $display("FAIL ar_tx%0d got %h exp ff", i, msh2); else pass++;
            chk++; if (rdd_2 !== sv[i]) $display("FAIL ar_rd%0d got %h exp %h", i, rdd_2, sv[i]); else pass++;
            prev = sv[i];
            @(posedge clk); #1;
        end
    endtask
`else
    task automatic test_autoread;
        int b0;
        b0 = bc2;
        @(posedge clk); #1 rd = 1'b1;
        @(posedge clk); #1 rd = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk++; if (bc2 !== b0) $display("FAIL rd_ignored got %0d exp %0d", bc2, b0); else pass++;
        chk++; if (busy_2 !== 1'b0) $display("FAIL rd_ignored_busy got %b exp 0", busy_2); else pass++;
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_cs_pending;
        test_wr_ignored;
        test_reset_mid;
        test_autoread;
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end
endmodule
